adc_led_sequencer: RTL and testbench

- Front end of the pulse-oximetry chain; produces the 8-bit ADC samples consumed by the RED and IR FIR filters.
- On each start request it runs one measurement frame:
  - drives the RED LED, waits for it to settle, then reads one serial ADC sample;
  - repeats the same for the IR LED;
  - publishes both samples together with a single valid strobe.
- Outputs RED_ADC_Value and IR_ADC_Value connect directly to the ADC_Value inputs of the RED and IR filters.

---
 rtl/pulse_ox_pkg.sv | 17 +
 rtl/adc_serial_rx.sv | 65 ++++++
 rtl/adc_led_sequencer.sv | 102 ++++++++++
 tb/tb_adc_led_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_ox_pkg.sv
// Shared types and defaults for the pulse-oximetry front end.
package pulse_ox_pkg;

  localparam int ADC_W          = 8;
  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_SETTLE_CYC = 16;

  typedef enum logic [2:0] {
    IDLE,
    RED_SETTLE,
    RED_READ,
    IR_SETTLE,
    IR_READ,
    PUBLISH
  } state_t;

endpackage

// File: rtl/adc_serial_rx.sv
// Serial ADC reader: one pulse on go runs a chip-select window of CLK_DIV setup
// cycles plus BITS SCLK periods, shifting adc_sdo in MSB first on each SCLK rise.
module adc_serial_rx
  import pulse_ox_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int BITS    = ADC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            go,
  input  logic            adc_sdo,
  output logic            done,
  output logic [BITS-1:0] data,
  output logic            adc_cs_n,
  output logic            adc_sclk
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W  = $clog2(2 * BITS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PHASE_LAST = PH_W'(2 * BITS);

  logic             active;
  logic [DIV_W-1:0] div;
  logic [PH_W-1:0]  phase;
  logic [BITS-1:0]  shift;

  // Phase 0 is setup; odd phases hold SCLK low, even phases hold it high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      div      <= '0;
      phase    <= '0;
      shift    <= '0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
    end else if (go) begin
      active   <= 1'b1;
      div      <= '0;
      phase    <= '0;
      adc_cs_n <= 1'b0;
      adc_sclk <= 1'b0;
    end else if (active) begin
      if (div == DIV_LAST) begin
        div <= '0;
        if (phase == PHASE_LAST) begin
          active   <= 1'b0;
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b0;
        end else begin
          phase    <= phase + 1'b1;
          adc_sclk <= phase[0];
          if (phase[0]) shift <= {shift[BITS-2:0], adc_sdo};
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  assign done = active && (div == DIV_LAST) && (phase == PHASE_LAST);
  assign data = shift;

endmodule

// File: rtl/adc_led_sequencer.sv
// Measurement frame sequencer: RED settle/read, IR settle/read, then publishes
// both samples with a single valid strobe.
module adc_led_sequencer
  import pulse_ox_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int ADC_BITS   = ADC_W
) (
  input  logic                CLK_Filter,
  input  logic                rst_n,
  input  logic                start,
  input  logic                clear_ovr,
  input  logic                adc_sdo,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  output logic                led_red,
  output logic                led_ir,
  output logic [ADC_BITS-1:0] RED_ADC_Value,
  output logic [ADC_BITS-1:0] IR_ADC_Value,
  output logic                sample_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  state_t              state, next_state;
  logic [SW-1:0]       settle_cnt;
  logic                settle_done;
  logic                go;
  logic                rx_done;
  logic [ADC_BITS-1:0] rx_data;
  logic [ADC_BITS-1:0] red_hold, ir_hold;

  adc_serial_rx #(
    .CLK_DIV(CLK_DIV),
    .BITS   (ADC_BITS)
  ) u_rx (
    .clk     (CLK_Filter),
    .rst_n   (rst_n),
    .go      (go),
    .adc_sdo (adc_sdo),
    .done    (rx_done),
    .data    (rx_data),
    .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk)
  );

  assign settle_done = (settle_cnt == SETTLE_LAST);

  always_comb begin
    next_state = state;
    go         = 1'b0;
    case (state)
      IDLE:       if (start) next_state = RED_SETTLE;
      RED_SETTLE: if (settle_done) begin next_state = RED_READ; go = 1'b1; end
      RED_READ:   if (rx_done) next_state = IR_SETTLE;
      IR_SETTLE:  if (settle_done) begin next_state = IR_READ; go = 1'b1; end
      IR_READ:    if (rx_done) next_state = PUBLISH;
      PUBLISH:    next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // LED and busy flops follow next_state so they line up with the state register.
  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      red_hold      <= '0;
      ir_hold       <= '0;
      led_red       <= 1'b0;
      led_ir        <= 1'b0;
      busy          <= 1'b0;
      sample_valid  <= 1'b0;
      RED_ADC_Value <= '0;
      IR_ADC_Value  <= '0;
      overrun       <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == RED_SETTLE || state == IR_SETTLE) && !settle_done)
        settle_cnt <= settle_cnt + 1'b1;
      else
        settle_cnt <= '0;
      if (state == RED_READ && rx_done) red_hold <= rx_data;
      if (state == IR_READ && rx_done)  ir_hold  <= rx_data;
      led_red      <= (next_state == RED_SETTLE) || (next_state == RED_READ);
      led_ir       <= (next_state == IR_SETTLE) || (next_state == IR_READ);
      busy         <= (next_state != IDLE);
      sample_valid <= (state == PUBLISH);
      if (state == PUBLISH) begin
        RED_ADC_Value <= red_hold;
        IR_ADC_Value  <= ir_hold;
      end
      if (start && state != IDLE) overrun <= 1'b1;
      else if (clear_ovr)         overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_led_sequencer.sv
// Scoreboard bench for adc_led_sequencer: frames are queued with expected samples,
// a monitor checks every published sample and that values hold between frames.
module tb_adc_led_sequencer;

  localparam int LAT      = 169;
  localparam int LAT_FAST = 37;

  logic       clk = 1'b0;
  logic       rst_n, start, clear_ovr, adc_sdo;
  logic       adc_cs_n, adc_sclk, led_red, led_ir, sample_valid, busy, overrun;
  logic [7:0] red_val, ir_val;

  logic       start_f, adc_sdo_f;
  logic       adc_cs_n_f, adc_sclk_f, led_red_f, led_ir_f, sample_valid_f, busy_f, overrun_f;
  logic [7:0] red_val_f, ir_val_f;

  logic [7:0] red_byte, ir_byte, red_byte_f, ir_byte_f;
  logic [2:0] bit_idx   = 3'd7;
  logic [2:0] bit_idx_f = 3'd7;

  int cyc = 0;
  int sclk_total = 0;
  int both_cnt = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] red;
    logic [7:0] ir;
    int         cyc;
    int         sclk_base;
    int         both_base;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] held_red = 8'h00;
  logic [7:0] held_ir  = 8'h00;

  always #5 clk = ~clk;

  adc_led_sequencer dut (
    .CLK_Filter(clk), .rst_n(rst_n), .start(start), .clear_ovr(clear_ovr),
    .adc_sdo(adc_sdo), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .led_red(led_red), .led_ir(led_ir), .RED_ADC_Value(red_val),
    .IR_ADC_Value(ir_val), .sample_valid(sample_valid), .busy(busy),
    .overrun(overrun)
  );

  adc_led_sequencer #(.CLK_DIV(1), .SETTLE_CYC(1)) dut_fast (
    .CLK_Filter(clk), .rst_n(rst_n), .start(start_f), .clear_ovr(clear_ovr),
    .adc_sdo(adc_sdo_f), .adc_cs_n(adc_cs_n_f), .adc_sclk(adc_sclk_f),
    .led_red(led_red_f), .led_ir(led_ir_f), .RED_ADC_Value(red_val_f),
    .IR_ADC_Value(ir_val_f), .sample_valid(sample_valid_f), .busy(busy_f),
    .overrun(overrun_f)
  );

  // ADC model: bit pointer restarts at chip-select release, advances after each SCLK rise.
  always @(posedge adc_sclk or posedge adc_cs_n)
    if (adc_cs_n) bit_idx <= 3'd7; else bit_idx <= bit_idx - 3'd1;
  always @(posedge adc_sclk_f or posedge adc_cs_n_f)
    if (adc_cs_n_f) bit_idx_f <= 3'd7; else bit_idx_f <= bit_idx_f - 3'd1;

  assign adc_sdo   = led_red ? red_byte[bit_idx] : (led_ir ? ir_byte[bit_idx] : 1'b0);
  assign adc_sdo_f = led_red_f ? red_byte_f[bit_idx_f] : (led_ir_f ? ir_byte_f[bit_idx_f] : 1'b0);

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge adc_sclk) sclk_total <= sclk_total + 1;
  always @(negedge clk) if (led_red && led_ir) both_cnt <= both_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per valid strobe, otherwise checks the held values.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_red = 8'h00;
      held_ir  = 8'h00;
    end else if (sample_valid) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("red_value", {24'd0, red_val}, {24'd0, e.red});
        checkOutput("ir_value", {24'd0, ir_val}, {24'd0, e.ir});
        checkOutput("latency", cyc, e.cyc);
        checkOutput("sclk_rises", sclk_total - e.sclk_base, 32'd16);
        checkOutput("led_overlap", both_cnt - e.both_base, 32'd0);
        held_red = e.red;
        held_ir  = e.ir;
      end
    end else begin
      checkOutput("red_hold", {24'd0, red_val}, {24'd0, held_red});
      checkOutput("ir_hold", {24'd0, ir_val}, {24'd0, held_ir});
    end
  end

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] i, output int k);
    exp_t e;
    @(negedge clk);
    red_byte    = r;
    ir_byte     = i;
    start       = 1'b1;
    k           = cyc + 1;
    e.red       = r;
    e.ir        = i;
    e.cyc       = k + LAT;
    e.sclk_base = sclk_total;
    e.both_base = both_cnt;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checkOutput("frame_timeout", 32'd1, 32'd0);
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int k;
    int n;
    rst_n = 1'b0; start = 1'b0; clear_ovr = 1'b0; start_f = 1'b0;
    red_byte = 8'h00; ir_byte = 8'h00; red_byte_f = 8'h00; ir_byte_f = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("idle_cs_n", {31'd0, adc_cs_n}, 32'd1);
    checkOutput("idle_sclk", {31'd0, adc_sclk}, 32'd0);
    checkOutput("idle_led_red", {31'd0, led_red}, 32'd0);
    checkOutput("idle_led_ir", {31'd0, led_ir}, 32'd0);
    checkOutput("idle_valid", {31'd0, sample_valid}, 32'd0);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_overrun", {31'd0, overrun}, 32'd0);
    checkOutput("idle_sclk_edges", sclk_total, 32'd0);

    applyStimulus(8'hA5, 8'h3C, k);
    checkOutput("busy_in_frame", {31'd0, busy}, 32'd1);
    waitDrain();

    applyStimulus(8'hFF, 8'h00, k);
    waitDrain();

    applyStimulus(8'h5A, 8'hC3, k);
    waitUntil(k + 39);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("overrun_set", {31'd0, overrun}, 32'd1);
    waitUntil(k + 59);
    start = 1'b1; clear_ovr = 1'b1;
    @(negedge clk);
    start = 1'b0; clear_ovr = 1'b0;
    checkOutput("overrun_set_wins", {31'd0, overrun}, 32'd1);
    clear_ovr = 1'b1;
    @(negedge clk);
    clear_ovr = 1'b0;
    checkOutput("overrun_cleared", {31'd0, overrun}, 32'd0);
    waitDrain();

    applyStimulus(8'h81, 8'h7E, k);
    waitUntil(k + 46);
    checkOutput("mid_read_cs_n", {31'd0, adc_cs_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    checkOutput("rst_cs_n", {31'd0, adc_cs_n}, 32'd1);
    checkOutput("rst_sclk", {31'd0, adc_sclk}, 32'd0);
    checkOutput("rst_leds", {30'd0, led_red, led_ir}, 32'd0);
    checkOutput("rst_values", {16'd0, red_val, ir_val}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h69, 8'h96, k);
    waitDrain();

    @(negedge clk);
    red_byte_f = 8'hC9;
    ir_byte_f  = 8'h36;
    start_f    = 1'b1;
    k          = cyc + 1;
    @(negedge clk);
    start_f = 1'b0;
    n = 0;
    while (!sample_valid_f && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fast_valid_seen", {31'd0, sample_valid_f}, 32'd1);
    checkOutput("fast_latency", cyc - k, LAT_FAST);
    checkOutput("fast_red", {24'd0, red_val_f}, 32'h0000_00C9);
    checkOutput("fast_ir", {24'd0, ir_val_f}, 32'h0000_0036);
    @(negedge clk);
    checkOutput("fast_valid_one_cycle", {31'd0, sample_valid_f}, 32'd0);
    checkOutput("fast_overrun", {31'd0, overrun_f}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
